// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: registers commands into a fixed-latency ALU and returns
// tagged results through a credit-limited in-order response FIFO.
module alu_cmd_driver #(
   parameter int W     = 128,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_opcode,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   input  logic [4:0]   cmd_shift,
   input  logic [3:0]   cmd_tag,
   output logic [3:0]   alu_opcode,
   output logic [W-1:0] alu_input1,
   output logic [W-1:0] alu_input2,
   output logic [4:0]   alu_shiftValue,
   input  logic [W-1:0] alu_result,
   input  logic         alu_carryFlag,
   input  logic         alu_zeroFlag,
   input  logic         alu_overFlowFlag,
   input  logic         alu_signFlag,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic [3:0]   rsp_tag,
   output logic [2:0]   inflight
);
   localparam int AW = $clog2(DEPTH);
   logic [4:0]   pipe [LAT];
   logic [AW:0]  count;
   logic [AW-1:0] wp, rp;
   logic [W-1:0] mem_res [DEPTH];
   logic [3:0]   mem_flg [DEPTH];
   logic [3:0]   mem_tag [DEPTH];
   logic         accept, push, pop;
   // Credits cover both buffered and in-flight entries, so a capture slot always exists.
   assign cmd_ready = rst && (int'(count) + int'(inflight) < DEPTH);
   assign accept    = cmd_valid && cmd_ready;
   assign push      = pipe[LAT-1][4];
   assign rsp_valid = count != '0;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_result = mem_res[rp];
   assign rsp_flags  = mem_flg[rp];
   assign rsp_tag    = mem_tag[rp];
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++)
         inflight = inflight + {2'b00, pipe[i][4]};
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_opcode     <= '0;
         alu_input1     <= '0;
         alu_input2     <= '0;
         alu_shiftValue <= '0;
         for (int i = 0; i < LAT; i++)
            pipe[i] <= '0;
         count <= '0;
         wp    <= '0;
         rp    <= '0;
      end else begin
         if (accept) begin
            alu_opcode     <= cmd_opcode;
            alu_input1     <= cmd_a;
            alu_input2     <= cmd_b;
            alu_shiftValue <= cmd_shift;
         end
         pipe[0] <= {accept, cmd_tag};
         for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wp] <= alu_result;
         mem_flg[wp] <= {alu_carryFlag, alu_overFlowFlag, alu_zeroFlag, alu_signFlag};
         mem_tag[wp] <= pipe[LAT-1][3:0];
      end
   end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed and random checks of alu_cmd_driver against a
// queue-based transaction model with a behavioural ALU stand-in.
module tb_alu_cmd_driver;
   localparam int W = 128, LAT = 2, DEPTH = 4;
   logic clk = 0, rst = 0, cmd_valid = 0, rsp_ready = 0;
   logic cmd_ready, rsp_valid;
   logic [3:0] cmd_opcode = '0, cmd_tag = '0, alu_opcode, rsp_flags, rsp_tag;
   logic [W-1:0] cmd_a = '0, cmd_b = '0, alu_input1, alu_input2, alu_result, rsp_result;
   logic [4:0] cmd_shift = '0, alu_shiftValue;
   logic alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;
   logic [2:0] inflight;
   typedef struct {logic [W+3:0] res; logic [3:0] tag; int acc;} ent_t;
   ent_t q[$];
   int cyc = 0, errors = 0, checks = 0, acc_cnt = 0;
   logic [3:0] l_op = '0;
   logic [W-1:0] l_a = '0, l_b = '0;
   logic [4:0] l_sh = '0;
   logic [3:0] d_op;
   logic [W-1:0] d_a, d_b;
   logic [4:0] d_sh;

   alu_cmd_driver #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
      .cmd_tag(cmd_tag), .alu_opcode(alu_opcode), .alu_input1(alu_input1),
      .alu_input2(alu_input2), .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
      .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
      .alu_overFlowFlag(alu_overFlowFlag), .alu_signFlag(alu_signFlag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .inflight(inflight));

   always #5 clk = ~clk;

   // Returns {carry, overflow, zero, sign, result}.
   function automatic logic [W+3:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, b, input logic [4:0] sh);
      logic [W:0] t;
      logic [W-1:0] r;
      logic v;
      t = '0;
      v = 1'b0;
      case (op)
         4'd0: begin t = {1'b0, a} + {1'b0, b}; v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]); end
         4'd1: begin t = {1'b0, a} - {1'b0, b}; v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]); end
         4'd2: t = {1'b0, a & b};
         4'd3: t = {1'b0, a | b};
         4'd4: t = {1'b0, a ^ b};
         4'd5: t = {1'b0, (a << sh) | (a >> (W - int'(sh)))};
         4'd6: t = (W+1)'($signed(a) < $signed(b));
         4'd7: t = (W+1)'(a < b);
         default: t = '0;
      endcase
      r = t[W-1:0];
      return {t[W], v, r == '0, r[W-1], r};
   endfunction

   // ALU stand-in: one register stage plus logic gives the LAT=2 result timing.
   always @(posedge clk) begin
      d_op <= alu_opcode;
      d_a  <= alu_input1;
      d_b  <= alu_input2;
      d_sh <= alu_shiftValue;
   end
   assign {alu_carryFlag, alu_overFlowFlag, alu_zeroFlag, alu_signFlag, alu_result} = alu_f(d_op, d_a, d_b, d_sh);

   function automatic logic [W-1:0] rand_w();
      return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [W+7:0] obs, input logic [W+7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, v, rr, input logic [3:0] op, input logic [W-1:0] a, b,
                       input logic [4:0] sh, input logic [3:0] tg);
      logic exp_ready, exp_valid;
      int infl;
      rst = r; cmd_valid = v; rsp_ready = rr;
      cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tg;
      #1;
      exp_ready = r && q.size() < DEPTH;
      exp_valid = q.size() > 0 && (cyc - q[0].acc) >= LAT;
      infl = 0;
      foreach (q[i]) if (cyc - q[i].acc < LAT) infl++;
      check("cmd_ready", cmd_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("inflight", inflight, infl);
      check("alu_op_sh", {alu_opcode, alu_shiftValue}, {l_op, l_sh});
      check("alu_in1", alu_input1, l_a);
      check("alu_in2", alu_input2, l_b);
      if (exp_valid) begin
         check("rsp_result", rsp_result, q[0].res[W-1:0]);
         check("rsp_flags", rsp_flags, q[0].res[W+3:W]);
         check("rsp_tag", rsp_tag, q[0].tag);
      end
      if (v && cmd_ready) acc_cnt++;
      @(posedge clk);
      cyc++;
      if (!r) begin
         q.delete();
         l_op = '0; l_a = '0; l_b = '0; l_sh = '0;
      end else begin
         if (exp_valid && rr) void'(q.pop_front());
         if (v && exp_ready) begin
            q.push_back(ent_t'{alu_f(op, a, b, sh), tg, cyc});
            l_op = op; l_a = a; l_b = b; l_sh = sh;
         end
      end
      @(negedge clk);
   endtask

   task automatic rstep(input logic r, v, rr, input logic [3:0] tg);
      step(r, v, rr, 4'($urandom_range(0, 7)), rand_w(), rand_w(), 5'($urandom), tg);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstep(0, 1, 1, 4'd0);
      rstep(1, 0, 0, 4'd0);
      check("ready_after_rst", cmd_ready, 1'b1);
      step(1, 1, 1, 4'd0, W'(5), W'(7), 5'd0, 4'd3);
      check("add_opcode", alu_opcode, 4'd0);
      check("add_in1", alu_input1, W'(5));
      rstep(1, 0, 1, 4'd0);
      check("add_not_early", rsp_valid, 1'b0);
      rstep(1, 0, 1, 4'd0);
      check("add_valid", rsp_valid, 1'b1);
      check("add_result", rsp_result, W'(12));
      check("add_tag", rsp_tag, 4'd3);
      rstep(1, 0, 1, 4'd0);
      step(1, 1, 1, 4'd1, W'(0), W'(1), 5'd0, 4'd5);
      repeat (2) rstep(1, 0, 1, 4'd0);
      check("sub_result", rsp_result, {W{1'b1}});
      check("sub_carry", rsp_flags[3], 1'b1);
      rstep(1, 0, 1, 4'd0);
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, 4'd0, W'(i), W'(i), 5'd0, 4'(i));
         if (i == 3) check("full_ready_low", cmd_ready, 1'b0);
      end
      check("full_accepts", acc_cnt, 4);
      repeat (2) rstep(1, 0, 0, 4'd0);
      check("full_valid", rsp_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("full_order", rsp_tag, 4'(i));
         rstep(1, 0, 1, 4'd0);
      end
      check("drained_ready", cmd_ready, 1'b1);
      check("drained_valid", rsp_valid, 1'b0);
      acc_cnt = 0;
      for (int i = 0; i < 16; i++) rstep(1, 1, 1, 4'(i));
      check("stream_accepts", acc_cnt, 16);
      repeat (4) rstep(1, 0, 1, 4'd0);
      rstep(1, 1, 0, 4'd10);
      rstep(1, 1, 0, 4'd11);
      rstep(1, 0, 0, 4'd0);
      check("one_head", rsp_tag, 4'd10);
      rstep(1, 0, 1, 4'd0);
      check("pushpop_valid", rsp_valid, 1'b1);
      check("pushpop_head", rsp_tag, 4'd11);
      rstep(1, 0, 1, 4'd0);
      for (int i = 0; i < 4; i++) rstep(1, 1, 0, 4'(i + 6));
      check("pre_rst_inflight", inflight, 3'd2);
      check("pre_rst_valid", rsp_valid, 1'b1);
      rstep(0, 0, 1, 4'd0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_inflight", inflight, 3'd0);
      repeat (6) rstep(1, 0, 1, 4'd0);
      for (int i = 0; i < 400; i++)
         rstep($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 4'($urandom));
      repeat (8) rstep(1, 0, 1, 4'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter W, default 128: operand and result width.
REQ-002 Parameter LAT, default 2: cycles from ALU operand drive edge to ALU result/flag valid.
REQ-003 Parameter DEPTH, default 4, power of two, ≥2: response buffer entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 cmd_opcode  input  4  ALU opcode (0 ADD … 7 SLTU).
REQ-009 cmd_a, cmd_b  input  W  operands.
REQ-010 cmd_shift  input  5  rotate amount.
REQ-011 cmd_tag  input  4  caller ID, returned with response.
REQ-012 alu_opcode / alu_input1 / alu_input2 / alu_shiftValue  output  4/W/W/5  registered drive to the ALU.
REQ-013 alu_result  input  W; alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag  input  1 each  ALU outputs.
REQ-014 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-015 rsp_result  output  W; rsp_flags  output  4 = {carry, overflow, zero, sign}; rsp_tag  output  4.
REQ-016 inflight  output  3  commands issued whose results are not yet captured.

Function
REQ-017 Accept = cmd_valid & cmd_ready; on accept, alu_* outputs load cmd_* fields at that edge.
REQ-018 With no accept, alu_* outputs SHALL hold their previous values.
REQ-019 A LAT-deep shift register of {valid, tag} SHALL advance every cycle; stage 0 loads {accept, cmd_tag}.
REQ-020 When the last stage is valid, alu_result and the four flags sampled that cycle SHALL be pushed into the response FIFO with its tag.
REQ-021 cmd_ready = (fifo_count + inflight < DEPTH); it never depends combinationally on cmd_valid.
REQ-022 FIFO SHALL never overflow; credit rule REQ-021 guarantees a capture slot for every in-flight command.
REQ-023 rsp_valid = (fifo_count != 0); head entry drives rsp_result/rsp_flags/rsp_tag; pop on rsp_valid & rsp_ready.
REQ-024 Simultaneous push and pop SHALL keep fifo_count unchanged and preserve order; push to an empty FIFO is visible on the next cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Responses SHALL leave in command acceptance order; minimum accept-to-rsp_valid latency = LAT+1 cycles.
REQ-027 Back-to-back accepts, one per cycle, SHALL be sustained while rsp_ready=1.
REQ-028 inflight = count of valid stages in the shift register; accept and capture in the same cycle leave it unchanged.
REQ-029 rsp_* outputs SHALL remain stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-030 While rst=0: alu_* outputs = 0, shift register valids = 0, FIFO empty, inflight = 0, rsp_valid = 0, cmd_ready = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered responses; no response for pre-reset commands appears afterward.
REQ-032 The first cycle with rst=1: cmd_ready = 1.

Verification
REQ-033 ADD a=5, b=7, tag=3, rsp_ready=1 -> alu_opcode=0 the next cycle; rsp_valid 3 cycles after accept with rsp_result=12, rsp_tag=3.
REQ-034 SUB a=0, b=1 -> rsp_result=all ones (W bits); rsp_flags carry bit = 1.
REQ-035 rsp_ready=0, 6 commands offered -> exactly 4 accepted, cmd_ready=0 after the 4th, FIFO holds 4; raise rsp_ready -> tags return in order, then cmd_ready=1.
REQ-036 Stream 16 commands back-to-back with rsp_ready=1 -> 16 accepts in 16 cycles, 16 in-order responses, pointers wrap without loss.
REQ-037 Assert rst=0 with 2 in flight and 2 buffered -> next cycle rsp_valid=0, inflight=0; no stale response after release.
REQ-038 FIFO at 1 entry, push and pop in the same cycle -> count stays 1; the new head is the pushed entry.
